unidad_muldiv: RTL and testbench



---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_paso.sv | 30 +++
 rtl/unidad_muldiv.sv | 167 ++++++++++++++++
 tb/tb_unidad_muldiv.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ITER    = 32;
    localparam int unsigned CNT_W   = $clog2(ITER);
    localparam int unsigned RD_W    = 5;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // Divide/remainder encodings all have funct3[2] set.
    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_paso.sv
// One iteration of the datapath: shift-add multiply step or restoring-divide step.
module muldiv_paso
    import muldiv_pkg::*;
(
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, operand};
        acc_next = {mul_sum, acc[XLEN-1:1]};
        if (is_div) begin
            if (diff[XLEN]) begin
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/unidad_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle magnitude datapath plus sign fix-up.
module unidad_muldiv
    import muldiv_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [RD_W-1:0]  rd_in,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [RD_W-1:0]  rd_out
);

    muldiv_state_t     state;
    muldiv_state_t     state_next;
    muldiv_op_t        op;
    muldiv_op_t        op_in;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd;
    logic [CNT_W-1:0]  cnt;
    logic [RD_W-1:0]   rd_q;
    logic              neg_res;
    logic              neg_rem;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_by_zero;
    logic              overflow;
    logic              special;
    logic [XLEN-1:0]   special_res;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;
    logic [XLEN-1:0]   result_d;
    logic [RD_W-1:0]   rd_d;
    logic              busy_d;
    logic              done_d;

    muldiv_paso u_paso (
        .is_div   (op_is_div(op)),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_next)
    );

    // Request decode: magnitudes, sign flags and the short-circuit cases.
    always_comb begin
        op_in       = muldiv_op_t'(funct3);
        a_neg       = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && rs1_data[XLEN-1];
        b_neg       = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && rs2_data[XLEN-1];
        a_mag       = a_neg ? (~rs1_data + XLEN'(1)) : rs1_data;
        b_mag       = b_neg ? (~rs2_data + XLEN'(1)) : rs2_data;
        div_by_zero = op_is_div(op_in) && (rs2_data == '0);
        overflow    = (op_in inside {OP_DIV, OP_REM}) && (rs1_data == INT_MIN) && (rs2_data == '1);
        special     = div_by_zero || overflow;
        if (div_by_zero) begin
            special_res = op_in[1] ? rs1_data : '1;
        end else begin
            special_res = op_in[1] ? '0 : INT_MIN;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = special ? DONE : CALC;
            CALC: if (cnt == CNT_W'(ITER - 1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: final sign correction and result selection.
    always_comb begin
        prod    = neg_res ? (~acc + (2*XLEN)'(1)) : acc;
        quo     = acc[XLEN-1:0];
        rem     = acc[2*XLEN-1:XLEN];
        fix_res = prod[2*XLEN-1:XLEN];
        case (op)
            OP_MUL:  fix_res = prod[XLEN-1:0];
            OP_DIV:  fix_res = neg_res ? (~quo + XLEN'(1)) : quo;
            OP_DIVU: fix_res = quo;
            OP_REM:  fix_res = neg_rem ? (~rem + XLEN'(1)) : rem;
            OP_REMU: fix_res = rem;
            default: fix_res = prod[2*XLEN-1:XLEN];
        endcase
        result_d = (state == IDLE) ? special_res : fix_res;
        rd_d     = (state == IDLE) ? rd_in : rd_q;
        busy_d   = (state_next != IDLE);
        done_d   = (state_next == DONE);
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            op      <= OP_MUL;
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            rd_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op      <= op_in;
                        rd_q    <= rd_in;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= '0;
                        if (op_is_div(op_in)) begin
                            acc  <= {{XLEN{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {{XLEN{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; result and rd_out only move on entry to DONE.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (done_d) begin
                result <= result_d;
                rd_out <= rd_d;
            end
        end
    end

endmodule

// File: tb/tb_unidad_muldiv.sv
// Directed and random checks of unidad_muldiv against a behavioural RV32M model.
module tb_unidad_muldiv;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int tests = 0;
    int fails = 0;
    logic [36:0] sb[$];

    unidad_muldiv dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb64;
        logic [63:0] p;
        logic ovf;
        sa   = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb64; return p[31:0]; end
            3'd1: begin p = sa * sb64; return p[63:32]; end
            3'd2: begin p = 64'(sa) * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Present a request for one cycle, then scramble the operand inputs.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        tick;
        start    = 1'b0;
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_in    = 5'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        logic [36:0] e;
        int cyc;
        sb.push_back({rd, exp});
        issue(f, a, b, rd);
        check({tag, ".busy"}, {31'b0, busy}, 32'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
        check({tag, ".lat"}, 32'(cyc), 32'(lat));
        e = (sb.size() > 0) ? sb.pop_front() : 37'd0;
        check({tag, ".result"}, result, e[31:0]);
        check({tag, ".rd"}, {27'b0, rd_out}, {27'b0, e[36:32]});
        tick;
        check({tag, ".pulse"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [36:0] e;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int dones;
        int dcyc;

        RST_n = 1'b0; start = 1'b0; funct3 = 3'd0;
        rs1_data = '0; rs2_data = '0; rd_in = '0;
        tick;
        tick;
        check("reset.state", {25'b0, busy, done, rd_out}, 32'd0);
        check("reset.result", result, 32'd0);
        RST_n = 1'b1;
        tick;

        run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34);
        run_op("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 34);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34);
        run_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 34);
        run_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 34);
        run_op("divu",    3'd5, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'h7FFF_FFFC, 34);
        run_op("divu0",   3'd5, 32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 1);
        run_op("remu0",   3'd7, 32'd5,          32'd0,         5'd11, 32'd5,         1);
        run_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         1);
        run_op("rd0",     3'd0, 32'd2,          32'd3,         5'd0,  32'd6,         34);

        for (int i = 0; i < 8; i++) begin
            f = 3'($urandom);
            a = $urandom;
            b = (i % 4 == 3) ? 32'd0 : $urandom;
            run_op("rand", f, a, b, 5'($urandom), ref_model(f, a, b), ref_latency(f, a, b));
        end

        // start at cycle 10 and in the DONE cycle must both be dropped
        sb.push_back({5'd9, 32'd391});
        issue(3'd0, 32'd17, 32'd23, 5'd9);
        dones = 0;
        dcyc  = 0;
        for (int c = 1; c <= 45; c++) begin
            if (done === 1'b1) begin
                dones++;
                dcyc = c;
            end
            start    = (c == 10) || (done === 1'b1);
            funct3   = 3'd5;
            rs2_data = 32'd0;
            tick;
        end
        start = 1'b0;
        e = (sb.size() > 0) ? sb.pop_front() : 37'd0;
        check("ignore.count", 32'(dones), 32'd1);
        check("ignore.cycle", 32'(dcyc), 32'd34);
        check("ignore.result", result, e[31:0]);

        // reset in cycle 20 of a divide aborts it silently
        issue(3'd4, 32'd1000, 32'd7, 5'd3);
        dones = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done === 1'b1) dones++;
            if (c == 20) RST_n = 1'b0;
            tick;
        end
        check("abort.done_seen", 32'(dones), 32'd0);
        check("abort.state", {25'b0, busy, done, rd_out}, 32'd0);
        check("abort.result", result, 32'd0);
        RST_n = 1'b1;
        run_op("after_abort", 3'd0, 32'd3, 32'd4, 5'd7, 32'd12, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
